line_data_memory: RTL and testbench

Backing data memory that serves the data cache's line-fill and write-back traffic. It is the responder end of the cache's memory interface: it accepts one 256-bit line request (enable/write/address), waits a fixed latency, performs the line read or write, and returns a single-cycle ack. It sits behind dcache_top's mem_* ports at the CPU top level.

---
 rtl/line_data_memory.sv | 125 ++++++++++++
 tb/tb_line_data_memory.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/line_data_memory.sv
// Line-granular backing data memory answering the data cache's fill/write-back requests.
// Optional misaligned-request flagging is enabled by defining DMEM_ALIGN_CHECK_EN.
module line_data_memory #(
    parameter int unsigned MEM_LATENCY = 10,
    parameter int unsigned DEPTH_LINES = 512,
    parameter int unsigned IDX_W       = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    input  logic         enable_i,
    input  logic         write_i,
    output logic         ack_o,
    output logic [255:0] data_o,
    output logic         err_o
);

    localparam int unsigned LINE_W = 256;
    localparam int unsigned CNT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [LINE_W-1:0] data;
        logic              write;
        logic              mis;
    } req_t;

    logic [LINE_W-1:0] mem [DEPTH_LINES];

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    req_t              req_q, req_d;
    logic              ack_d, err_d;
    logic [LINE_W-1:0] data_d;
    logic              mem_we_c;
    logic              mis_c;

`ifdef DMEM_ALIGN_CHECK_EN
    assign mis_c = |addr_i[4:0];
`else
    assign mis_c = 1'b0;
`endif

    // High address bits alias onto the array; offset bits only matter for the alignment check
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[31:IDX_W+5], addr_i[4:0]};

    // Next-state, request latch and registered-output precursors
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        data_d   = data_o;
        mem_we_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    req_d.idx   = addr_i[IDX_W+4:5];
                    req_d.data  = data_i;
                    req_d.write = write_i;
                    req_d.mis   = mis_c;
                    cnt_d       = CNT_W'(MEM_LATENCY - 1);
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ACK;
                    ack_d   = 1'b1;
                    err_d   = req_q.mis;
                    if (!req_q.mis) begin
                        if (req_q.write) begin
                            mem_we_c = 1'b1;
                        end else begin
                            data_d = mem[req_q.idx];
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            ack_o   <= 1'b0;
            err_o   <= 1'b0;
            data_o  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            ack_o   <= ack_d;
            err_o   <= err_d;
            data_o  <= data_d;
        end
    end

    // Storage array is intentionally not reset
    always_ff @(posedge clk_i) begin
        if (mem_we_c) begin
            mem[req_q.idx] <= req_q.data;
        end
    end

endmodule

// File: tb/tb_line_data_memory.sv
// Scoreboard bench for line_data_memory: driver pushes expected acks, monitor pops and compares.
module tb_line_data_memory;

    localparam int unsigned LAT = 4;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic [31:0]  addr_i = '0;
    logic [255:0] data_i = '0;
    logic         enable_i = 1'b0;
    logic         write_i = 1'b0;
    logic         ack_o;
    logic [255:0] data_o;
    logic         err_o;

    line_data_memory #(.MEM_LATENCY(LAT), .DEPTH_LINES(512), .IDX_W(9)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .addr_i   (addr_i),
        .data_i   (data_i),
        .enable_i (enable_i),
        .write_i  (write_i),
        .ack_o    (ack_o),
        .data_o   (data_o),
        .err_o    (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int           ack_cyc;
        logic [255:0] data;
        logic         err;
        bit           chk_data;
    } exp_t;

    exp_t         sb[$];
    int           n_vec = 0;
    int           n_bad = 0;
    int           cyc = 0;
    logic [255:0] model [int];
    logic [255:0] last_read = '0;
    bit           last_known = 1'b1;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Monitor: every ack must match the oldest expectation; read data must persist one more cycle
    bit           hold_pend = 1'b0;
    logic [255:0] hold_val;
    always @(negedge clk_i) begin
        if (hold_pend) begin
            hold_pend = 1'b0;
            n_vec++;
            if (data_o !== hold_val) begin
                n_bad++;
                $display("FAIL data_hold: got %h want %h", data_o, hold_val);
            end
        end
        if (rst_i && ack_o) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_ack: got ack_o=1 at cycle %0d want no ack", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                n_vec++;
                if (cyc != e.ack_cyc) begin
                    n_bad++;
                    $display("FAIL ack_cycle: got %0d want %0d", cyc, e.ack_cyc);
                end
                n_vec++;
                if (err_o !== e.err) begin
                    n_bad++;
                    $display("FAIL err_o: got %b want %b", err_o, e.err);
                end
                if (e.chk_data) begin
                    n_vec++;
                    if (data_o !== e.data) begin
                        n_bad++;
                        $display("FAIL ack_data: got %h want %h", data_o, e.data);
                    end
                    hold_pend = 1'b1;
                    hold_val  = e.data;
                end
            end
        end
    end

    // Drive a request from a negedge; predict its ack from the accepting edge
    task automatic start_req(input logic [31:0] addr, input logic wr, input logic [255:0] wdata,
                             input int accept_cyc, input bit push);
        int   idx;
        logic mis;
        exp_t e;
        addr_i   = addr;
        write_i  = wr;
        data_i   = wdata;
        enable_i = 1'b1;
        idx = int'(addr[13:5]);
`ifdef DMEM_ALIGN_CHECK_EN
        mis = (addr[4:0] != 5'd0);
`else
        mis = 1'b0;
`endif
        if (push) begin
            if (!mis) begin
                if (wr) begin
                    model[idx] = wdata;
                end else if (model.exists(idx)) begin
                    last_read  = model[idx];
                    last_known = 1'b1;
                end else begin
                    last_known = 1'b0;
                end
            end
            e.ack_cyc  = accept_cyc + LAT;
            e.data     = last_read;
            e.err      = mis;
            e.chk_data = last_known;
            sb.push_back(e);
        end
    endtask

    task automatic wait_ack();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (ack_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL ack_timeout: got no ack within 40 cycles want ack");
        end
    endtask

    task automatic do_req(input logic [31:0] addr, input logic wr, input logic [255:0] wdata);
        start_req(addr, wr, wdata, cyc + 1, 1'b1);
        wait_ack();
        enable_i = 1'b0;
        @(negedge clk_i);
    endtask

    logic [255:0] pat_a5, pat_p1, pat_p2, pat_p3;

    initial begin
        pat_a5 = {32{8'hA5}};
        pat_p1 = {8{32'h1234_5678}};
        pat_p2 = {8{32'hDEAD_BEEF}};
        pat_p3 = {8{32'h0F0F_0F0F}};

        repeat (3) @(negedge clk_i);
        n_vec++;
        if (ack_o !== 1'b0) begin n_bad++; $display("FAIL rst_ack: got %b want 0", ack_o); end
        n_vec++;
        if (err_o !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err_o); end
        n_vec++;
        if (data_o !== '0) begin n_bad++; $display("FAIL rst_data: got %h want 0", data_o); end
        rst_i = 1'b1;
        @(negedge clk_i);

        // Write then read line 2; data_o stays 0 through the write ack
        do_req(32'h0000_0040, 1'b1, pat_a5);
        do_req(32'h0000_0040, 1'b0, '0);

        // Alias: 0x4020 and 0x20 both map to index 1
        do_req(32'h0000_4020, 1'b1, pat_p1);
        do_req(32'h0000_0020, 1'b0, '0);

        // Back-to-back with enable held across the ack
        start_req(32'h0000_0080, 1'b1, pat_p2, cyc + 1, 1'b1);
        wait_ack();
        start_req(32'h0000_0080, 1'b0, '0, cyc + 2, 1'b1);
        wait_ack();
        enable_i = 1'b0;
        @(negedge clk_i);

        // Write ack must leave previously read data on data_o
        do_req(32'h0000_00A0, 1'b1, pat_p3);

        // Reset two cycles into BUSY aborts the write
        start_req(32'h0000_0020, 1'b1, pat_p3, cyc + 1, 1'b0);
        repeat (3) @(negedge clk_i);
        rst_i    = 1'b0;
        enable_i = 1'b0;
        #1;
        n_vec++;
        if (ack_o !== 1'b0) begin n_bad++; $display("FAIL abort_ack: got %b want 0", ack_o); end
        n_vec++;
        if (data_o !== '0) begin n_bad++; $display("FAIL abort_data: got %h want 0", data_o); end
        last_read  = '0;
        last_known = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        repeat (4) @(negedge clk_i);
        do_req(32'h0000_0020, 1'b0, '0);

`ifdef DMEM_ALIGN_CHECK_EN
        // Misaligned write flags err_o and must not touch line 2
        do_req(32'h0000_0044, 1'b1, pat_p3);
        do_req(32'h0000_0040, 1'b0, '0);
`endif

        // Never-written line: only timing and err are predictable
        do_req(32'h0000_0300, 1'b0, '0);

        repeat (6) @(negedge clk_i);
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: got %0d pending want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1);
    end

endmodule
